burst_mem_slave: RTL

On-chip SSRAM bus slave that answers burst transactions on the shared system bus. It is the target the DMA custom-instruction master reads from, and later writes to. It decodes a configurable address window and streams `burstSize+1` words per read burst. Write bursts are accepted and stored with byte enables. Out-of-window or misaligned accesses are answered with a bus error.

---
 rtl/burst_mem_slave_if.sv | 27 ++
 rtl/burst_mem_slave.sv | 138 +++++++++++++
 2 files changed

// File: rtl/burst_mem_slave_if.sv
// System-bus signal bundle between a burst master and burst_mem_slave.
// Signal names follow the slave's point of view: *In is driven by the master, *Out by the slave.
interface burst_mem_slave_if;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic        readNotWriteIn;
    logic [7:0]  burstSizeIn;
    logic [3:0]  byteEnablesIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busErrorOut;

    modport master (
        output beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
               byteEnablesIn, dataValidIn, endTransactionIn,
        input  addressDataOut, dataValidOut, endTransactionOut, busErrorOut
    );

    modport slave (
        input  beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
               byteEnablesIn, dataValidIn, endTransactionIn,
        output addressDataOut, dataValidOut, endTransactionOut, busErrorOut
    );
endinterface

// File: rtl/burst_mem_slave.sv
// On-chip SSRAM burst slave: window decode, streamed read bursts, byte-enabled write bursts, bus errors.
// Optional BURST_MEM_SLAVE_WAITSTATE_EN inserts one idle cycle after every read word.
module burst_mem_slave #(
    parameter logic [31:0] baseAddress = 32'h5000_0000,
    parameter int unsigned addrBits    = 10
) (
    input logic              clock,
    input logic              reset,
    burst_mem_slave_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, RD_GAP, RD_END, WR, ERR_MID, ERR_END
    } state_t;

    localparam int unsigned         DEPTH    = 1 << addrBits;
    localparam logic [addrBits-1:0] LAST_IDX = '1;
    localparam logic [addrBits-1:0] ONE_IDX  = {{(addrBits-1){1'b0}}, 1'b1};

    state_t              state_q, state_d, adv_state;
    logic [addrBits-1:0] idx_q, idx_d, rd_idx;
    logic [8:0]          cnt_q, cnt_d;
    logic [7:0]          burst_q, burst_d;
    logic [3:0]          be_q, be_d;
    logic                past_end_q, past_end_d;
    logic [31:0]         rdata_q;
    logic                dv_q, end_q, err_q;
    logic                wr_en, wr_err_d;
    logic                hit, misaligned;
    logic [31:0]         mem [DEPTH];

    assign hit        = bus.addressDataIn[31:addrBits+2] == baseAddress[31:addrBits+2];
    assign misaligned = bus.addressDataIn[1:0] != 2'b00;

    // Word limit takes precedence over the window edge: a burst ending exactly on the last word is clean.
    assign adv_state = (cnt_q == {1'b0, burst_q}) ? RD_END :
                       (idx_q == LAST_IDX)        ? ERR_MID : RD_DATA;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        burst_d    = burst_q;
        be_d       = be_q;
        past_end_d = past_end_q;
        rd_idx     = idx_q;
        wr_en      = 1'b0;
        wr_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.beginTransactionIn && hit) begin
                    idx_d      = bus.addressDataIn[addrBits+1:2];
                    cnt_d      = '0;
                    burst_d    = bus.burstSizeIn;
                    be_d       = bus.byteEnablesIn;
                    past_end_d = 1'b0;
                    if (misaligned)              state_d = ERR_END;
                    else if (bus.readNotWriteIn) state_d = RD_ADDR;
                    else                         state_d = WR;
                end
            end
            RD_ADDR: state_d = bus.endTransactionIn ? IDLE : RD_DATA;
            RD_DATA: begin
                if (bus.endTransactionIn) begin
                    state_d = IDLE;
                end else begin
`ifdef BURST_MEM_SLAVE_WAITSTATE_EN
                    state_d = RD_GAP;
`else
                    state_d = adv_state;
`endif
                end
            end
            RD_GAP:  state_d = bus.endTransactionIn ? IDLE : adv_state;
            RD_END:  state_d = IDLE;
            WR: begin
                if (bus.dataValidIn) begin
                    if (cnt_q <= {1'b0, burst_q} && !past_end_q) begin
                        wr_en = 1'b1;
                        idx_d = idx_q + ONE_IDX;
                        cnt_d = cnt_q + 9'd1;
                        if (idx_q == LAST_IDX) past_end_d = 1'b1;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
                if (bus.endTransactionIn) state_d = IDLE;
            end
            ERR_MID: state_d = ERR_END;
            ERR_END: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == RD_DATA && state_q != RD_ADDR) begin
            rd_idx = idx_q + ONE_IDX;
            idx_d  = idx_q + ONE_IDX;
            cnt_d  = cnt_q + 9'd1;
        end
    end

    // Outputs are decoded from the next state so they are registered and zero whenever the slave is quiet.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            burst_q    <= '0;
            be_q       <= '0;
            past_end_q <= 1'b0;
            rdata_q    <= '0;
            dv_q       <= 1'b0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            burst_q    <= burst_d;
            be_q       <= be_d;
            past_end_q <= past_end_d;
            rdata_q    <= (state_d == RD_DATA) ? mem[rd_idx] : '0;
            dv_q       <= (state_d == RD_DATA);
            end_q      <= (state_d == RD_END) || (state_d == ERR_END);
            err_q      <= (state_d == ERR_MID) || (state_d == ERR_END) || wr_err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx_q][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
            end
        end
    end

    assign bus.addressDataOut    = rdata_q;
    assign bus.dataValidOut      = dv_q;
    assign bus.endTransactionOut = end_q;
    assign bus.busErrorOut       = err_q;
endmodule
